// File: rtl/crc_cfu_engine.sv
// crc_cfu_engine: table-driven reflected CRC custom-function unit on the CFU request/response channel
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cfu_req_valid/ready           request handshake (ready only in IDLE)
//   cfu_req_id                    request tag, echoed on cfu_resp_id
//   cfu_req_function_id           0/1/2 = update 1/2/4 bytes, 3 = finalize, 4..7 illegal
//   cfu_req_data0                 message bytes, byte 0 (bits [7:0]) consumed first
//   cfu_req_data1                 current CRC state
//   cfu_resp_valid/ready          response handshake, response held until accepted
//   cfu_resp_id, _status, _data   echoed tag, 1 = illegal function, zero-extended CRC
module crc_cfu_engine #(
  parameter int CRC_WIDTH = 32,
  parameter logic [31:0] POLY = 32'hEDB88320,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF,
  parameter int BYTES_PER_CYCLE = 1,
  parameter int ID_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfu_req_valid,
  output logic                cfu_req_ready,
  input  logic [ID_WIDTH-1:0] cfu_req_id,
  input  logic [2:0]          cfu_req_function_id,
  input  logic [31:0]         cfu_req_data0,
  input  logic [31:0]         cfu_req_data1,
  output logic                cfu_resp_valid,
  input  logic                cfu_resp_ready,
  output logic [ID_WIDTH-1:0] cfu_resp_id,
  output logic                cfu_resp_status,
  output logic [31:0]         cfu_resp_data
);
  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4) || CRC_WIDTH < 8 || CRC_WIDTH > 32) begin : g_bad_params
    $error("crc_cfu_engine: illegal CRC_WIDTH or BYTES_PER_CYCLE");
  end
  localparam logic [CRC_WIDTH-1:0] P = POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] X = XOROUT[CRC_WIDTH-1:0];
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  function automatic logic [CRC_WIDTH-1:0] tbl_entry(input int n);
    logic [CRC_WIDTH-1:0] c;
    c = CRC_WIDTH'(n);
    for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ P : c >> 1;
    return c;
  endfunction
  logic [CRC_WIDTH-1:0] tbl [256];
  for (genvar i = 0; i < 256; i++) begin : g_tbl
    assign tbl[i] = tbl_entry(i);
  end
  state_t               state;
  logic [CRC_WIDTH-1:0] crc, c_nxt, d1m;
  logic [31:0]          data, d_nxt;
  logic [2:0]           count, fold, nbytes;
  assign cfu_req_ready = state == IDLE;
  assign d1m = cfu_req_data1[CRC_WIDTH-1:0];
  assign nbytes = cfu_req_function_id == 3'd0 ? 3'd1 : cfu_req_function_id == 3'd1 ? 3'd2 : 3'd4;
  // Unrolled byte chain; stages beyond the remaining count pass through untouched.
  always_comb begin
    c_nxt = crc;
    d_nxt = data;
    fold = '0;
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      if (3'(k) < count) begin
        c_nxt = (c_nxt >> 8) ^ tbl[c_nxt[7:0] ^ d_nxt[7:0]];
        d_nxt = d_nxt >> 8;
        fold = fold + 3'd1;
      end
    end
  end
  // resp_valid rises on the first edge spent in RESP, so all operations share one exit path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      crc <= '0;
      data <= '0;
      count <= '0;
      cfu_resp_valid <= 1'b0;
      cfu_resp_id <= '0;
      cfu_resp_status <= 1'b0;
      cfu_resp_data <= '0;
    end else begin
      case (state)
        IDLE: if (cfu_req_valid) begin
          cfu_resp_id <= cfu_req_id;
          data <= cfu_req_data0;
          crc <= d1m;
          count <= nbytes;
          if (cfu_req_function_id < 3'd3) state <= CALC;
          else begin
            state <= RESP;
            cfu_resp_status <= cfu_req_function_id != 3'd3;
            cfu_resp_data <= cfu_req_function_id == 3'd3 ? 32'(d1m ^ X) : '0;
          end
        end
        CALC: begin
          crc <= c_nxt;
          data <= d_nxt;
          count <= count - fold;
          if (count == fold) begin
            state <= RESP;
            cfu_resp_data <= 32'(c_nxt);
            cfu_resp_status <= 1'b0;
          end
        end
        RESP: if (!cfu_resp_valid) cfu_resp_valid <= 1'b1;
        else if (cfu_resp_ready) begin
          cfu_resp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_cfu_engine.sv
// tb_crc_cfu_engine: directed self-checking bench for crc_cfu_engine (BPC=1 and BPC=4 instances)
module tb_crc_cfu_engine;
  logic        clk = 0, rst;
  logic        req_valid, req_valid4, resp_ready, sel;
  logic [3:0]  req_id;
  logic [2:0]  func;
  logic [31:0] d0, d1;
  logic        ready1, ready4, valid1, valid4, status1, status4;
  logic [3:0]  id1, id4;
  logic [31:0] data1, data4;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  crc_cfu_engine #(.BYTES_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .cfu_req_valid(req_valid), .cfu_req_ready(ready1),
    .cfu_req_id(req_id), .cfu_req_function_id(func), .cfu_req_data0(d0), .cfu_req_data1(d1),
    .cfu_resp_valid(valid1), .cfu_resp_ready(resp_ready), .cfu_resp_id(id1),
    .cfu_resp_status(status1), .cfu_resp_data(data1));
  crc_cfu_engine #(.BYTES_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .cfu_req_valid(req_valid4), .cfu_req_ready(ready4),
    .cfu_req_id(req_id), .cfu_req_function_id(func), .cfu_req_data0(d0), .cfu_req_data1(d1),
    .cfu_resp_valid(valid4), .cfu_resp_ready(resp_ready), .cfu_resp_id(id4),
    .cfu_resp_status(status4), .cfu_resp_data(data4));
  wire        r_ready  = sel ? ready4 : ready1;
  wire        r_valid  = sel ? valid4 : valid1;
  wire        r_status = sel ? status4 : status1;
  wire [3:0]  r_id     = sel ? id4 : id1;
  wire [31:0] r_data   = sel ? data4 : data1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Drives one request and returns the edge (accept edge = 0) at which resp_valid is first seen.
  task automatic issue(input logic [3:0] id, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int lat);
    int n;
    req_id = id; func = f; d0 = a; d1 = b;
    n = 0;
    while (!r_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (sel) req_valid4 = 1; else req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0; req_valid4 = 0;
    lat = 0;
    while (!r_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask
  initial begin
    int lat, n;
    logic ok;
    rst = 1; req_valid = 0; req_valid4 = 0; resp_ready = 1; sel = 0;
    req_id = 0; func = 0; d0 = 0; d1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_ready", 32'(r_ready), 32'd1);
    check("rst_valid", 32'(r_valid), 32'd0);
    check("rst_data", r_data, 32'd0);
    check("rst_id", 32'(r_id), 32'd0);
    check("rst_status", 32'(r_status), 32'd0);
    issue(4'd3, 3'd0, 32'h61, 32'hFFFFFFFF, lat);
    check("f0_lat", 32'(lat), 32'd2);
    check("f0_data", r_data, 32'h174841BC);
    check("f0_status", 32'(r_status), 32'd0);
    check("f0_id", 32'(r_id), 32'd3);
    issue(4'd4, 3'd3, 32'h0, 32'h174841BC, lat);
    check("f3_lat", 32'(lat), 32'd1);
    check("f3_data", r_data, 32'hE8B7BE43);
    issue(4'd5, 3'd2, 32'h34333231, 32'hFFFFFFFF, lat);
    check("f2_bpc1_lat", 32'(lat), 32'd5);
    check("f2_bpc1_data", r_data, 32'h641C1F5C);
    sel = 1;
    issue(4'd6, 3'd2, 32'h34333231, 32'hFFFFFFFF, lat);
    check("f2_bpc4_lat", 32'(lat), 32'd2);
    check("f2_bpc4_data", r_data, 32'h641C1F5C);
    sel = 0;
    issue(4'd9, 3'd5, 32'h12345678, 32'hFFFFFFFF, lat);
    check("f5_lat", 32'(lat), 32'd1);
    check("f5_status", 32'(r_status), 32'd1);
    check("f5_data", r_data, 32'd0);
    check("f5_id", 32'(r_id), 32'd9);
    @(posedge clk); #1;
    req_id = 1; func = 2; d0 = 32'h34333231; d1 = 32'hFFFFFFFF;
    n = 0;
    while (!ready1 && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1;
    @(posedge clk); #1;
    req_id = 2; func = 0; d0 = 32'h61;
    check("busy_ready", 32'(ready1), 32'd0);
    n = 0;
    while (!valid1 && n < 50) begin @(posedge clk); #1; n++; end
    check("busy_first_id", 32'(id1), 32'd1);
    check("busy_first_data", data1, 32'h641C1F5C);
    n = 0;
    while (!ready1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!valid1 && n < 50) begin @(posedge clk); #1; n++; end
    check("busy_second_id", 32'(id1), 32'd2);
    check("busy_second_data", data1, 32'h174841BC);
    @(posedge clk); #1;
    resp_ready = 0;
    issue(4'd7, 3'd0, 32'h61, 32'hFFFFFFFF, lat);
    check("hold_lat", 32'(lat), 32'd2);
    ok = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!valid1 || data1 !== 32'h174841BC || id1 !== 4'd7 || status1 !== 1'b0 || ready1) ok = 0;
    end
    check("hold_stable", 32'(ok), 32'd1);
    resp_ready = 1;
    @(posedge clk); #1;
    check("hold_valid_drop", 32'(valid1), 32'd0);
    check("hold_ready_back", 32'(ready1), 32'd1);
    req_id = 8; func = 2; d0 = 32'h34333231; d1 = 32'hFFFFFFFF;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    #2 rst = 0;
    check("rst_mid_ready", 32'(ready1), 32'd1);
    check("rst_mid_data", data1, 32'd0);
    ok = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (valid1) ok = 0;
    end
    check("rst_mid_no_resp", 32'(ok), 32'd1);
    issue(4'd3, 3'd0, 32'h61, 32'hFFFFFFFF, lat);
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_data", data1, 32'h174841BC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
